// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 byte-stream program loader.
package mips32_pkg;

  // Loader states, in frame order.
  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    START   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_e;

  // Frame overhead around the payload.
  localparam int HDR_BYTES   = 2;
  localparam int CKSUM_BYTES = 1;

endpackage

// File: rtl/mips32_word_assembler.sv
// Packs a stream of bytes into big-endian 32-bit words.
// word_last is a same-cycle strobe on the 4th byte of a word; word_valid
// pulses one cycle later, and word then holds the completed word until
// the next one finishes.
module mips32_word_assembler (
  input  logic        clk1,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_last
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  assign word_last  = byte_valid && (byte_cnt_q == 2'd3);
  assign word       = word_q;
  assign word_valid = word_valid_q;

  // Shift bytes in MSB first and latch the word on its 4th byte.
  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise a
    // path that skips an assignment infers a latch.
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_valid) begin
      shift_d    = {shift_q[15:0], byte_in};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    if (word_last) begin
      word_d       = {shift_q, byte_in};
      word_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk1) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/mips32_boot_loader.sv
// Framed byte-stream loader for pipe_MIPS32: parses a 16-bit word count,
// writes the payload words from address 0, verifies an XOR checksum and
// then releases the core with a one-cycle start pulse.
module mips32_boot_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word count limit in the same 16-bit unsigned domain as the header.
  localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        count_hi_q, count_hi_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       widx_q, widx_d;
  logic [7:0]        cksum_q, cksum_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              core_hold_q, core_hold_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        accept;
  logic        byte_stb;
  logic        word_last;
  logic [15:0] hdr_count;

  assign in_ready  = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                     (state_q == PAYLOAD) || (state_q == CHECK);
  assign accept    = in_valid && in_ready;
  assign byte_stb  = accept && (state_q == PAYLOAD);
  assign hdr_count = {count_hi_q, in_byte};

  mips32_word_assembler u_asm (
    .clk1       (clk1),
    .rst        (rst),
    .byte_valid (byte_stb),
    .byte_in    (in_byte),
    .word       (mem_wdata),
    .word_valid (mem_we),
    .word_last  (word_last)
  );

  assign mem_addr   = mem_addr_q;
  assign core_hold  = core_hold_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Frame parser: next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    count_hi_d   = count_hi_q;
    count_d      = count_q;
    widx_d       = widx_q;
    cksum_d      = cksum_q;
    mem_addr_d   = mem_addr_q;
    core_hold_d  = core_hold_q;
    core_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      HDR_HI: if (accept) begin
        count_hi_d = in_byte;
        busy_d     = 1'b1;
        state_d    = HDR_LO;
      end
      HDR_LO: if (accept) begin
        count_d = hdr_count;
        if ((hdr_count == 16'd0) || (hdr_count > MAX_WORDS_W)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept) begin
        cksum_d = cksum_q ^ in_byte;
        if (word_last) begin
          mem_addr_d = widx_q[ADDR_W-1:0];
          widx_d     = widx_q + 16'd1;
          if (widx_q == count_q - 16'd1) state_d = CHECK;
        end
      end
      CHECK: if (accept) begin
        busy_d = 1'b0;
        if (in_byte == cksum_q) begin
          state_d      = START;
          core_start_d = 1'b1;
          core_hold_d  = 1'b0;
          done_d       = 1'b1;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      START:   state_d = DONE;
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = HDR_HI;
    endcase
  end

  // Parser registers; reset parks the core and clears the load context.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= HDR_HI;
      count_hi_q   <= '0;
      count_q      <= '0;
      widx_q       <= '0;
      cksum_q      <= '0;
      mem_addr_q   <= '0;
      core_hold_q  <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_hi_q   <= count_hi_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      cksum_q      <= cksum_d;
      mem_addr_q   <= mem_addr_d;
      core_hold_q  <= core_hold_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Self-checking bench for mips32_boot_loader: a frame-level reference
// model predicts every output each cycle; directed scenarios add literal
// end-of-load expectations.
module tb_mips32_boot_loader;
  import mips32_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              core_start;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk1 = ~clk1;

  mips32_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .core_start (core_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  // Tracks position in the frame of every accepted byte and derives the
  // expected outputs for the following cycle from the frame rules.
  int                m_pos, m_count;
  logic [7:0]        m_hi, m_xor;
  logic [31:0]       m_word, m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_ready, m_we, m_start, m_busy, m_done, m_err, m_hold;

  always @(posedge clk1) begin
    if (rst) begin
      m_pos <= 0; m_count <= 0; m_hi <= '0; m_xor <= '0; m_word <= '0;
      m_data <= '0; m_addr <= '0; m_ready <= 1'b1; m_we <= 1'b0;
      m_start <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_hold <= 1'b1;
    end else begin
      m_we    <= 1'b0;
      m_start <= 1'b0;
      if (in_valid && m_ready) begin
        m_pos <= m_pos + 1;
        if (m_pos == 0) begin
          m_hi   <= in_byte;
          m_busy <= 1'b1;
        end else if (m_pos == 1) begin
          m_count <= int'({16'd0, m_hi, in_byte});
          if ({m_hi, in_byte} == 16'd0 || int'({16'd0, m_hi, in_byte}) > MAX_WORDS) begin
            m_err <= 1'b1; m_busy <= 1'b0; m_ready <= 1'b0;
          end
        end else if (m_pos < 2 + 4 * m_count) begin
          m_word <= {m_word[23:0], in_byte};
          m_xor  <= m_xor ^ in_byte;
          if ((m_pos - 2) % 4 == 3) begin
            m_we   <= 1'b1;
            m_addr <= ADDR_W'((m_pos - 2) / 4);
            m_data <= {m_word[23:0], in_byte};
          end
        end else begin
          m_busy  <= 1'b0;
          m_ready <= 1'b0;
          if (in_byte == m_xor) begin
            m_done <= 1'b1; m_hold <= 1'b0; m_start <= 1'b1;
          end else begin
            m_err <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and write capture ----------------
  logic [31:0] tb_mem [0:15];
  int          n_we    = 0;
  int          n_start = 0;

  always @(negedge clk1) begin
    check("in_ready",   32'(in_ready),   32'(m_ready));
    check("mem_we",     32'(mem_we),     32'(m_we));
    check("mem_addr",   32'(mem_addr),   32'(m_addr));
    if (m_we) check("mem_wdata", mem_wdata, m_data);
    check("core_hold",  32'(core_hold),  32'(m_hold));
    check("core_start", 32'(core_start), 32'(m_start));
    check("busy",       32'(busy),       32'(m_busy));
    check("done",       32'(done),       32'(m_done));
    check("err",        32'(err),        32'(m_err));
    if (mem_we) begin
      if (mem_addr < 16) tb_mem[mem_addr[3:0]] <= mem_wdata;
      n_we <= n_we + 1;
    end
    if (core_start) n_start <= n_start + 1;
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  frame [$];
  logic [31:0] words [$];

  task automatic build_frame();
    logic [7:0] x;
    logic [31:0] w;
    frame.delete();
    x = 8'h00;
    frame.push_back(8'(words.size() >> 8));
    frame.push_back(8'(words.size()));
    foreach (words[i]) begin
      w = words[i];
      for (int b = 3; b >= 0; b--) begin
        frame.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    frame.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk1);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk1);
    in_valid = 1'b1;
    in_byte  = b;
  endtask

  task automatic send_frame(input int n_bytes, input bit gaps);
    for (int i = 0; i < n_bytes && i < frame.size(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(frame[i]);
    end
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  int we0, st0;

  initial begin
    // Reset state.
    do_reset();
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst core_hold", 32'(core_hold), 32'd1);
    check("rst mem_wdata", mem_wdata,      32'd0);
    check("rst mem_addr",  32'(mem_addr),  32'd0);
    check("rst busy",      32'(busy),      32'd0);

    // Good two-word load at full rate.
    words = '{32'h2801000A, 32'hFC000000};
    build_frame();
    check("frame1 cksum", 32'(frame[frame.size() - CKSUM_BYTES]), 32'hDF);
    we0 = n_we; st0 = n_start;
    send_frame(frame.size(), 1'b0);
    idle(4);
    check("s1 writes",    32'(n_we - we0),    32'd2);
    check("s1 mem0",      tb_mem[0],          32'h2801000A);
    check("s1 mem1",      tb_mem[1],          32'hFC000000);
    check("s1 starts",    32'(n_start - st0), 32'd1);
    check("s1 done",      32'(done),          32'd1);
    check("s1 core_hold", 32'(core_hold),     32'd0);
    check("s1 err",       32'(err),           32'd0);

    // Nine-word program with random valid gaps.
    do_reset();
    words = '{32'h2801000A, 32'h28020014, 32'h28030019, 32'h0CE77800, 32'h0CE77800,
              32'h00222000, 32'h0CE77800, 32'h00832800, 32'hFC000000};
    build_frame();
    check("frame9 cksum", 32'(frame[frame.size() - CKSUM_BYTES]), 32'hE9);
    we0 = n_we; st0 = n_start;
    send_frame(frame.size(), 1'b1);
    idle(4);
    check("s2 writes", 32'(n_we - we0), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("s2 mem%0d", i), tb_mem[i], words[i]);
    check("s2 done", 32'(done), 32'd1);

    // Bad checksum: words still land, core stays halted.
    do_reset();
    words = '{32'h2801000A, 32'hFC000000};
    build_frame();
    frame[frame.size() - CKSUM_BYTES] = 8'hDE;
    we0 = n_we; st0 = n_start;
    send_frame(frame.size(), 1'b0);
    send(8'h55);
    send(8'hAA);
    idle(3);
    check("s3 writes",    32'(n_we - we0),    32'd2);
    check("s3 err",       32'(err),           32'd1);
    check("s3 core_hold", 32'(core_hold),     32'd1);
    check("s3 starts",    32'(n_start - st0), 32'd0);
    check("s3 in_ready",  32'(in_ready),      32'd0);

    // Illegal counts: zero and MAX_WORDS+1.
    do_reset();
    we0 = n_we;
    frame = '{8'h00, 8'h00};
    send_frame(HDR_BYTES, 1'b0);
    check("s4 zero err", 32'(err), 32'd1);
    do_reset();
    frame = '{8'h04, 8'h01};
    send_frame(HDR_BYTES, 1'b0);
    check("s4 1025 err", 32'(err),         32'd1);
    check("s4 writes",   32'(n_we - we0),  32'd0);
    // Exactly MAX_WORDS is legal.
    do_reset();
    frame = '{8'h04, 8'h00};
    send_frame(HDR_BYTES, 1'b0);
    check("s4 1024 err",      32'(err),      32'd0);
    check("s4 1024 busy",     32'(busy),     32'd1);
    check("s4 1024 in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of the payload, then a clean reload.
    do_reset();
    words = '{32'h2801000A, 32'hFC000000};
    build_frame();
    send_frame(HDR_BYTES + 6, 1'b0);
    do_reset();
    check("s5 rst busy",      32'(busy),      32'd0);
    check("s5 rst core_hold", 32'(core_hold), 32'd1);
    check("s5 rst mem_addr",  32'(mem_addr),  32'd0);
    check("s5 rst in_ready",  32'(in_ready),  32'd1);
    tb_mem[0] = 32'h0;
    tb_mem[1] = 32'h0;
    we0 = n_we; st0 = n_start;
    send_frame(frame.size(), 1'b0);
    idle(4);
    check("s5 writes", 32'(n_we - we0),    32'd2);
    check("s5 mem0",   tb_mem[0],          32'h2801000A);
    check("s5 mem1",   tb_mem[1],          32'hFC000000);
    check("s5 starts", 32'(n_start - st0), 32'd1);
    check("s5 done",   32'(done),          32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
